// File: rtl/hazard_fwd_pkg.sv
// Shared constants and helpers for the forwarding/hazard controller.
package hazard_fwd_pkg;

    // Forward select value meaning "take the operand from the register file".
    localparam int SEL_RF = 0;

    function automatic int sel_w(input int num_stages);
        return (num_stages > 1) ? $clog2(num_stages) : 1;
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_prio_match.sv
// Priority matcher: finds the youngest (lowest index) live stage whose rd equals rs_i.
module fwd_prio_match #(
    parameter int NUM_STAGES = 3,
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 2
) (
    input  logic [REG_ADDR_W-1:0]            rs_i,
    input  logic [NUM_STAGES*REG_ADDR_W-1:0] stg_rd_i,
    input  logic [NUM_STAGES-1:0]            stg_live_i,
    output logic                             hit_o,
    output logic [SEL_W-1:0]                 idx_o
);

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (stg_live_i[k] && (stg_rd_i[k*REG_ADDR_W +: REG_ADDR_W] == rs_i)) begin
                hit_o = 1'b1;
                idx_o = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding + hazard controller: shadow pipeline EXE..WB, per-port forward selects, ID stalls.
// Build option FWD_WB_BYPASS_EN: when defined, the last tracked stage (WB) also forwards to EXE.
module hazard_fwd_ctrl
    import hazard_fwd_pkg::*;
#(
    parameter int  NUM_RS         = 2,
    parameter int  REG_ADDR_W     = 5,
    parameter int  NUM_STAGES     = 3,
    parameter int  LOAD_READY_STG = 2,
    parameter int  CNT_W          = 32,
    localparam int SEL_W          = sel_w(NUM_STAGES)
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         id_valid,
    input  logic [NUM_RS*REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0]        id_rd,
    input  logic                         id_reg_write,
    input  logic                         id_mem_read,
    input  logic                         flush,
    output logic                         stall,
    output logic [NUM_RS*SEL_W-1:0]      fwd_sel,
    output logic [CNT_W-1:0]             stall_cnt
);

`ifdef FWD_WB_BYPASS_EN
    localparam int FMAX = NUM_STAGES - 1;
`else
    localparam int FMAX = NUM_STAGES - 2;
`endif

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  is_load;
    } stage_entry_t;

    stage_entry_t                 st_q [NUM_STAGES];
    stage_entry_t                 st_d [NUM_STAGES];
    logic [NUM_RS*REG_ADDR_W-1:0] rs0_q, rs0_d;
    logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

    logic [NUM_STAGES*REG_ADDR_W-1:0] stg_rd;
    logic [NUM_STAGES-1:0]            stg_live, stg_load, fwd_live, haz_live;

    always_comb begin
        stg_rd   = '0;
        stg_live = '0;
        stg_load = '0;
        fwd_live = '0;
        haz_live = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            stg_rd[k*REG_ADDR_W +: REG_ADDR_W] = st_q[k].rd;
            stg_live[k] = st_q[k].valid & st_q[k].we & (st_q[k].rd != '0);
            stg_load[k] = st_q[k].is_load;
            fwd_live[k] = stg_live[k] & (k >= 1) & (k <= FMAX);
            // The last stage writes the reg file before ID reads it, so it never blocks ID.
            haz_live[k] = stg_live[k] & (k <= NUM_STAGES - 2);
        end
    end

    logic [NUM_RS-1:0] fwd_hit, haz_hit;
    logic [SEL_W-1:0]  fwd_idx [NUM_RS];
    logic [SEL_W-1:0]  haz_idx [NUM_RS];

    for (genvar p = 0; p < NUM_RS; p++) begin : g_port
        fwd_prio_match #(
            .NUM_STAGES (NUM_STAGES),
            .REG_ADDR_W (REG_ADDR_W),
            .SEL_W      (SEL_W)
        ) u_fwd (
            .rs_i       (rs0_q[p*REG_ADDR_W +: REG_ADDR_W]),
            .stg_rd_i   (stg_rd),
            .stg_live_i (fwd_live),
            .hit_o      (fwd_hit[p]),
            .idx_o      (fwd_idx[p])
        );

        fwd_prio_match #(
            .NUM_STAGES (NUM_STAGES),
            .REG_ADDR_W (REG_ADDR_W),
            .SEL_W      (SEL_W)
        ) u_haz (
            .rs_i       (id_rs[p*REG_ADDR_W +: REG_ADDR_W]),
            .stg_rd_i   (stg_rd),
            .stg_live_i (haz_live),
            .hit_o      (haz_hit[p]),
            .idx_o      (haz_idx[p])
        );

        assign fwd_sel[p*SEL_W +: SEL_W] = (st_q[0].valid && fwd_hit[p]) ? fwd_idx[p]
                                                                          : SEL_W'(SEL_RF);
    end

    // A match at stage k meets the consumer at stage k+1 once the consumer reaches EXE.
    logic need_stall;
    always_comb begin
        need_stall = 1'b0;
        for (int p = 0; p < NUM_RS; p++) begin
            if (haz_hit[p]) begin
                if (int'(haz_idx[p]) + 1 > FMAX) begin
                    need_stall = 1'b1;
                end
                if (stg_load[haz_idx[p]] && (int'(haz_idx[p]) + 1 < LOAD_READY_STG)) begin
                    need_stall = 1'b1;
                end
            end
        end
    end

    assign stall = need_stall & id_valid & ~flush;

    always_comb begin
        st_d[0] = '0;
        rs0_d   = '0;
        if (!(stall || flush)) begin
            st_d[0].valid   = id_valid;
            st_d[0].rd      = id_rd;
            st_d[0].we      = id_reg_write;
            st_d[0].is_load = id_mem_read;
            rs0_d           = id_rs;
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
            st_d[k] = st_q[k-1];
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                st_q[k] <= '0;
            end
            rs0_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            st_q        <= st_d;
            rs0_q       <= rs0_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl; expectations follow FWD_WB_BYPASS_EN when it is defined.
module tb_hazard_fwd_ctrl;

    logic        clk          = 1'b0;
    logic        arst_n       = 1'b1;
    logic        id_valid     = 1'b0;
    logic [9:0]  id_rs        = '0;
    logic [4:0]  id_rd        = '0;
    logic        id_reg_write = 1'b0;
    logic        id_mem_read  = 1'b0;
    logic        flush        = 1'b0;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [31:0] stall_cnt;

    int tests   = 0;
    int fails   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (stall),
        .fwd_sel      (fwd_sel),
        .stall_cnt    (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in ID: rs1 goes to port 0, rs2 to port 1.
    task automatic issue(input int v, input int rd, input int rs1, input int rs2,
                         input int we, input int ld);
        id_valid     = 1'(v);
        id_rd        = 5'(rd);
        id_rs        = {5'(rs2), 5'(rs1)};
        id_reg_write = 1'(we);
        id_mem_read  = 1'(ld);
        #2;
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        #2 arst_n = 1'b0;
        #2;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd", 32'(fwd_sel), 0);
        chk("rst_cnt", stall_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1 arst_n = 1'b1;

        // ALU producer followed directly by a dependent on both ports
        issue(1, 5, 1, 2, 1, 0);
        chk("t1_prod_stall", 32'(stall), 0);
        tick();
        issue(1, 6, 5, 5, 1, 0);
        chk("t1_raw_stall", 32'(stall), 0);
        tick();
        nop();
        chk("t1_fwd", 32'(fwd_sel), 32'b0101);
        drain();

        // load-use on port 1
        issue(1, 7, 1, 0, 1, 1);
        chk("t2_ld_stall", 32'(stall), 0);
        tick();
        issue(1, 8, 0, 7, 1, 0);
        chk("t2_lu_stall", 32'(stall), 1);
        exp_cnt++;
        tick();
        chk("t2_bubble_fwd", 32'(fwd_sel), 0);
        chk("t2_cnt", stall_cnt, 32'(exp_cnt));
`ifdef FWD_WB_BYPASS_EN
        chk("t2_stall_end", 32'(stall), 0);
        tick();
        nop();
        chk("t2_fwd_wb", 32'(fwd_sel), 32'b1000);
`else
        // load now in MEM; without WB forwarding the dependent waits for the reg file
        chk("t2_stall_wb", 32'(stall), 1);
        exp_cnt++;
        tick();
        chk("t2_stall_end", 32'(stall), 0);
        tick();
        nop();
        chk("t2_fwd_rf", 32'(fwd_sel), 0);
`endif
        chk("t2_cnt_final", stall_cnt, 32'(exp_cnt));
        drain();

        // x9 written by two producers: youngest (MEM) wins on port 1
        issue(1, 9, 1, 2, 1, 0);
        tick();
        issue(1, 9, 1, 2, 1, 0);
        tick();
        issue(1, 20, 3, 9, 1, 0);
        chk("t3_stall", 32'(stall), 0);
        tick();
        nop();
        chk("t3_fwd", 32'(fwd_sel), 32'b0100);
        drain();

        // x0 is never a live producer, even as a load destination
        issue(1, 0, 1, 2, 1, 1);
        tick();
        issue(1, 21, 0, 0, 1, 0);
        chk("t4_x0_stall", 32'(stall), 0);
        tick();
        nop();
        chk("t4_x0_fwd", 32'(fwd_sel), 0);
        drain();

        // producer two instructions ahead on port 0
        issue(1, 10, 1, 2, 1, 0);
        tick();
        issue(1, 11, 1, 2, 1, 0);
        tick();
        issue(1, 22, 10, 1, 1, 0);
`ifdef FWD_WB_BYPASS_EN
        chk("t5_stall", 32'(stall), 0);
        tick();
        nop();
        chk("t5_fwd_wb", 32'(fwd_sel), 32'b0010);
`else
        chk("t5_stall", 32'(stall), 1);
        exp_cnt++;
        tick();
        chk("t5_stall_end", 32'(stall), 0);
        tick();
        nop();
        chk("t5_fwd_rf", 32'(fwd_sel), 0);
`endif
        chk("t5_cnt", stall_cnt, 32'(exp_cnt));
        drain();

        // flush overrides a load-use stall
        issue(1, 12, 1, 2, 1, 1);
        tick();
        issue(1, 23, 12, 0, 1, 0);
        chk("t6_pre_flush_stall", 32'(stall), 1);
        flush = 1'b1;
        #1;
        chk("t6_flush_stall", 32'(stall), 0);
        tick();
        flush = 1'b0;
        nop();
        chk("t6_flush_cnt", stall_cnt, 32'(exp_cnt));
        chk("t6_flush_bubble", 32'(fwd_sel), 0);
        drain();

        // async reset in the middle of a load-use stall with an active forward
        issue(1, 14, 1, 2, 1, 0);
        tick();
        issue(1, 13, 14, 0, 1, 1);
        chk("t6_ld_stall", 32'(stall), 0);
        tick();
        issue(1, 24, 0, 13, 1, 0);
        chk("t6_lu_stall", 32'(stall), 1);
        chk("t6_lu_fwd", 32'(fwd_sel), 32'b0001);
        chk("t6_lu_cnt", stall_cnt, 32'(exp_cnt));
        arst_n = 1'b0;
        #1;
        chk("t6_rst_stall", 32'(stall), 0);
        chk("t6_rst_fwd", 32'(fwd_sel), 0);
        chk("t6_rst_cnt", stall_cnt, 0);
        #2 arst_n = 1'b1;
        nop();
        tick();
        chk("t6_post_rst_cnt", stall_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
